// File: rtl/ysyx_23060201_lsu_load_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060201_lsu_load_pkg
// Shared definitions for the load-side LSU:
//   - RV32 load funct3 codes (LB/LH/LW/LBU/LHU)
//   - FSM state encoding (2 bits)
//   - helper functions classifying a load as illegal or misaligned
// ---------------------------------------------------------------------------
package ysyx_23060201_lsu_load_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } load_state_e;

  // True for the five load encodings RV32I defines.
  function automatic logic isLegalLoad(input logic [2:0] funct3);
    logic legal;
    legal = 1'b0;
    case (funct3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
      default:                             legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic isMisaligned(input logic [2:0] funct3,
                                        input logic [1:0] addrLo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_LH, F3_LHU: mis = addrLo[0];
      F3_LW:         mis = |addrLo;
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx_23060201_lsu_load_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060201_lsu_load_if
// Bundles the three handshakes of the load unit:
//   req_*  : EXU -> LSU load request (valid/ready, byte address, funct3)
//   mem_*  : LSU -> memory read port (AR valid/ready/addr, R valid/ready/data)
//   rsp_*  : LSU -> WBU load result (valid/ready, data, error flag)
// Modport slave is the LSU side, master is the environment (EXU/memory/WBU).
// ---------------------------------------------------------------------------
interface ysyx_23060201_lsu_load_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_funct3;

  logic                  mem_arvalid;
  logic                  mem_arready;
  logic [ADDR_WIDTH-1:0] mem_araddr;
  logic                  mem_rvalid;
  logic                  mem_rready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  modport slave (
    input  req_valid, req_addr, req_funct3,
    output req_ready,
    output mem_arvalid, mem_araddr, mem_rready,
    input  mem_arready, mem_rvalid, mem_rdata,
    output rsp_valid, rsp_data, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_addr, req_funct3,
    input  req_ready,
    input  mem_arvalid, mem_araddr, mem_rready,
    output mem_arready, mem_rvalid, mem_rdata,
    input  rsp_valid, rsp_data, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/ysyx_23060201_lsu_load_ext.sv
// ---------------------------------------------------------------------------
// ysyx_23060201_lsu_load_ext
// Combinational load formatter.
//   i_rdata      : aligned 32-bit memory word
//   i_addrLo     : byte offset within the word
//   i_funct3     : load type
//   o_result     : selected byte/halfword/word, sign- or zero-extended
//   o_misaligned : access crosses its natural alignment
//   o_illegal    : funct3 is not a load encoding
// ---------------------------------------------------------------------------
module ysyx_23060201_lsu_load_ext
  import ysyx_23060201_lsu_load_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addrLo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result,
  output logic        o_misaligned,
  output logic        o_illegal
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte lane follows addr[1:0]; halfword lane follows addr[1] only.
  assign w_byte = i_rdata[{i_addrLo, 3'b000} +: 8];
  assign w_half = i_rdata[{i_addrLo[1], 4'b0000} +: 16];

  always_comb begin
    o_result = '0;
    case (i_funct3)
      F3_LB:   o_result = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_result = {24'd0, w_byte};
      F3_LH:   o_result = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_result = {16'd0, w_half};
      F3_LW:   o_result = i_rdata;
      default: o_result = '0;
    endcase
  end

  assign o_misaligned = isMisaligned(i_funct3, i_addrLo);
  assign o_illegal    = ~isLegalLoad(i_funct3);

endmodule

// File: rtl/ysyx_23060201_lsu_load.sv
// ---------------------------------------------------------------------------
// ysyx_23060201_lsu_load
// Blocking load unit: accepts one load from EXU, fetches the aligned word
// from data memory, formats it and hands the result to WBU.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   io_bus : request / memory-read / response handshakes (slave modport)
// Parameters: ADDR_WIDTH, DATA_WIDTH (32 for RV32), TIMEOUT_CYC (WAIT cycles
// allowed before the load is answered with an error).
// ---------------------------------------------------------------------------
module ysyx_23060201_lsu_load
  import ysyx_23060201_lsu_load_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ysyx_23060201_lsu_load_if.slave   io_bus
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  load_state_e           r_state;
  load_state_e           w_stateNext;
  logic                  r_drain;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_funct3;
  logic [DATA_WIDTH-1:0] r_rspData;
  logic                  r_rspErr;

  logic                  w_accept;
  logic                  w_accErr;
  logic                  w_timeout;
  logic [1:0]            w_selAddrLo;
  logic [2:0]            w_selFunct3;
  logic [DATA_WIDTH-1:0] w_extData;
  logic                  w_misaligned;
  logic                  w_illegal;

  // A single formatter serves both the accept-time legality check (live
  // request in IDLE) and the data extraction (latched request in WAIT).
  assign w_selAddrLo = (r_state == ST_IDLE) ? io_bus.req_addr[1:0] : r_addr[1:0];
  assign w_selFunct3 = (r_state == ST_IDLE) ? io_bus.req_funct3    : r_funct3;

  ysyx_23060201_lsu_load_ext u_ext (
    .i_rdata      (io_bus.mem_rdata),
    .i_addrLo     (w_selAddrLo),
    .i_funct3     (w_selFunct3),
    .o_result     (w_extData),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );

  assign w_accept  = io_bus.req_valid & io_bus.req_ready;
  assign w_accErr  = w_misaligned | w_illegal;
  // Fires on the TIMEOUT_CYC-th consecutive WAIT cycle without read data.
  assign w_timeout = (r_state == ST_WAIT) & ~io_bus.mem_rvalid & (r_cnt == CNT_LAST);

  // While draining, no new load may start so a late beat cannot be taken
  // as the data of a different load.
  assign io_bus.req_ready   = (r_state == ST_IDLE) & ~r_drain;
  assign io_bus.mem_arvalid = (r_state == ST_AR);
  assign io_bus.mem_araddr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign io_bus.mem_rready  = (r_state == ST_WAIT) | r_drain;
  assign io_bus.rsp_valid   = (r_state == ST_RESP);
  assign io_bus.rsp_data    = r_rspData;
  assign io_bus.rsp_err     = r_rspErr;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic: errors detected at accept bypass memory entirely.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)              w_stateNext = w_accErr ? ST_RESP : ST_AR;
      ST_AR:   if (io_bus.mem_arready)    w_stateNext = ST_WAIT;
      ST_WAIT: if (io_bus.mem_rvalid | w_timeout) w_stateNext = ST_RESP;
      ST_RESP: if (io_bus.rsp_ready)      w_stateNext = ST_IDLE;
      default:                            w_stateNext = ST_IDLE;
    endcase
  end

  // Datapath: request latch, timeout counter, drain flag and response regs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drain   <= 1'b0;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_funct3  <= '0;
      r_rspData <= '0;
      r_rspErr  <= 1'b0;
    end else begin
      if (r_drain && io_bus.mem_rvalid) begin
        r_drain <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr   <= io_bus.req_addr;
            r_funct3 <= io_bus.req_funct3;
            if (w_accErr) begin
              r_rspData <= '0;
              r_rspErr  <= 1'b1;
            end
          end
        end
        ST_AR: begin
          if (io_bus.mem_arready) begin
            r_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (io_bus.mem_rvalid) begin
            r_rspData <= w_extData;
            r_rspErr  <= 1'b0;
          end else if (w_timeout) begin
            r_rspData <= '0;
            r_rspErr  <= 1'b1;
            r_drain   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_lsu_load.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060201_lsu_load
// Self-checking bench for the load unit, built with TIMEOUT_CYC=8. Acts as
// EXU, memory and WBU; expected results come from a behavioural load model.
// ---------------------------------------------------------------------------
module tb_ysyx_23060201_lsu_load;

  localparam int TMO = 8;

  logic clk;
  logic rst_n;

  int testsRun    = 0;
  int testsFailed = 0;
  int arHs        = 0;
  int rspHs       = 0;
  int arCycles    = 0;

  ysyx_23060201_lsu_load_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ysyx_23060201_lsu_load #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor: counts address and response handshakes and any
  // cycle with the address channel valid.
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.mem_arvalid && bus.mem_arready) arHs++;
      if (bus.rsp_valid && bus.rsp_ready)     rspHs++;
      if (bus.mem_arvalid)                    arCycles++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural RV32 load: pick bytes by arithmetic on the address offset.
  function automatic void refLoad(input logic [31:0] addr, input logic [2:0] f3,
                                  input logic [31:0] word,
                                  output logic [31:0] data, output logic err);
    int unsigned off;
    int unsigned b;
    int unsigned h;
    off  = addr % 4;
    b    = (word >> (8 * off)) & 32'hFF;
    h    = (word >> (16 * (off / 2))) & 32'hFFFF;
    data = 32'd0;
    err  = 1'b0;
    case (f3)
      3'd0: data = (b >= 128) ? b - 32'd256 : b;
      3'd4: data = b;
      3'd1: if (addr % 2 != 0) err = 1'b1; else data = (h >= 32768) ? h - 32'd65536 : h;
      3'd5: if (addr % 2 != 0) err = 1'b1; else data = h;
      3'd2: if (off != 0) err = 1'b1; else data = word;
      default: err = 1'b1;
    endcase
  endfunction

  // One complete load with chosen memory and WBU delays, checked cycle by cycle.
  task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                               input logic [31:0] word, input int arDelay, input int rDelay,
                               input int rspDelay);
    logic [31:0] expData;
    logic        expErr;
    int          arBefore;
    int          rspBefore;
    int          arCycBefore;
    refLoad(addr, f3, word, expData, expErr);
    arBefore    = arHs;
    rspBefore   = rspHs;
    arCycBefore = arCycles;
    checkOutput({tag, ".req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_funct3 = f3;
    tick();
    bus.req_valid  = 1'b0;
    bus.req_addr   = $urandom;
    bus.req_funct3 = 3'($urandom);
    if (!expErr) begin
      for (int k = 0; k <= arDelay; k++) begin
        checkOutput({tag, ".arvalid"}, {31'd0, bus.mem_arvalid}, 32'd1);
        checkOutput({tag, ".araddr"}, bus.mem_araddr, addr & 32'hFFFF_FFFC);
        checkOutput({tag, ".rsp_idle_ar"}, {31'd0, bus.rsp_valid}, 32'd0);
        bus.mem_arready = (k == arDelay);
        tick();
      end
      bus.mem_arready = 1'b0;
      for (int k = 0; k <= rDelay; k++) begin
        checkOutput({tag, ".rready"}, {31'd0, bus.mem_rready}, 32'd1);
        checkOutput({tag, ".rsp_idle_wait"}, {31'd0, bus.rsp_valid}, 32'd0);
        bus.mem_rvalid = (k == rDelay);
        bus.mem_rdata  = (k == rDelay) ? word : $urandom;
        tick();
      end
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
    end
    for (int k = 0; k <= rspDelay; k++) begin
      checkOutput({tag, ".rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
      checkOutput({tag, ".rsp_data"}, bus.rsp_data, expData);
      checkOutput({tag, ".rsp_err"}, {31'd0, bus.rsp_err}, {31'd0, expErr});
      checkOutput({tag, ".req_ready_busy"}, {31'd0, bus.req_ready}, 32'd0);
      bus.rsp_ready = (k == rspDelay);
      tick();
    end
    bus.rsp_ready = 1'b0;
    checkOutput({tag, ".rsp_done"}, {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput({tag, ".ar_hs"}, arHs - arBefore, expErr ? 32'd0 : 32'd1);
    checkOutput({tag, ".rsp_hs"}, rspHs - rspBefore, 32'd1);
    if (expErr)
      checkOutput({tag, ".no_arvalid"}, arCycles - arCycBefore, 32'd0);
  endtask

  initial begin
    logic [31:0] rAddr;
    rst_n           = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_addr    = '0;
    bus.req_funct3  = '0;
    bus.mem_arready = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = '0;
    bus.rsp_ready   = 1'b0;

    // Reset state.
    repeat (3) tick();
    checkOutput("rst.arvalid", {31'd0, bus.mem_arvalid}, 32'd0);
    checkOutput("rst.rready", {31'd0, bus.mem_rready}, 32'd0);
    checkOutput("rst.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("rst.rsp_data", bus.rsp_data, 32'd0);
    checkOutput("rst.rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("rst.req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Directed loads.
    applyStimulus("lw_fast", 32'h8000_0004, 3'b010, 32'hDEAD_BEEF, 0, 0, 0);
    applyStimulus("lb",      32'h8000_0003, 3'b000, 32'h80FF_0011, 0, 0, 0);
    applyStimulus("lbu",     32'h8000_0003, 3'b100, 32'h80FF_0011, 1, 0, 0);
    applyStimulus("lhu",     32'h8000_0002, 3'b101, 32'h80FF_0011, 0, 1, 0);
    applyStimulus("lh",      32'h8000_0000, 3'b001, 32'h80FF_0011, 0, 0, 1);
    applyStimulus("lh_mis",  32'h8000_0001, 3'b001, 32'h80FF_0011, 0, 0, 0);
    applyStimulus("f3_011",  32'h8000_0000, 3'b011, 32'h80FF_0011, 0, 0, 2);
    applyStimulus("lw_slow", 32'h8000_0108, 3'b010, 32'h1234_5678, 4, 7, 3);

    // Timeout: no read data, then a late beat must be swallowed.
    checkOutput("tmo.req_ready", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h8000_0010;
    bus.req_funct3 = 3'b010;
    tick();
    bus.req_valid   = 1'b0;
    bus.mem_arready = 1'b1;
    checkOutput("tmo.arvalid", {31'd0, bus.mem_arvalid}, 32'd1);
    tick();
    bus.mem_arready = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      checkOutput("tmo.waiting", {31'd0, bus.rsp_valid}, 32'd0);
      tick();
    end
    checkOutput("tmo.rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    checkOutput("tmo.rsp_err", {31'd0, bus.rsp_err}, 32'd1);
    checkOutput("tmo.rsp_data", bus.rsp_data, 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("drain.req_ready", {31'd0, bus.req_ready}, 32'd0);
      checkOutput("drain.rready", {31'd0, bus.mem_rready}, 32'd1);
      tick();
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_1111;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.req_valid  = 1'b0;
    checkOutput("drain.no_accept", {31'd0, bus.mem_arvalid}, 32'd0);
    checkOutput("drain.cleared", {31'd0, bus.mem_rready}, 32'd0);
    applyStimulus("post_drain", 32'h8000_0014, 3'b010, 32'h2222_2222, 1, 2, 0);

    // Reset while waiting for read data.
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h8000_0020;
    bus.req_funct3 = 3'b010;
    tick();
    bus.req_valid   = 1'b0;
    bus.mem_arready = 1'b1;
    tick();
    bus.mem_arready = 1'b0;
    tick();
    checkOutput("mid.rready", {31'd0, bus.mem_rready}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid.arvalid", {31'd0, bus.mem_arvalid}, 32'd0);
    checkOutput("mid.rready_rst", {31'd0, bus.mem_rready}, 32'd0);
    checkOutput("mid.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("mid.rsp_data", bus.rsp_data, 32'd0);
    checkOutput("mid.rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("mid.req_ready", {31'd0, bus.req_ready}, 32'd1);
    applyStimulus("after_rst", 32'h8000_0024, 3'b010, 32'hCAFE_F00D, 0, 0, 0);

    // Randomised loads, including misaligned and illegal encodings.
    for (int n = 0; n < 40; n++) begin
      rAddr = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
      applyStimulus("rand", rAddr, 3'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
